// File: rtl/sync_feed_fifo_pkg.sv
// Shared constants for the sync_multi feed FIFO: default widths and
// issue FSM state encodings.
package sync_feed_fifo_pkg;

    localparam int DATA_WIDTHS = 8;
    localparam int FEED_DEPTH  = 4;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/sync_feed_mem.sv
// DEPTH x DATA_WIDTH register array, one write port and one
// combinational read port.
module sync_feed_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_feed_fifo.sv
// Buffers producer words and hands them one at a time to sync_multi,
// waiting for its busy flag to rise and fall between transfers.
module sync_feed_fifo
    import sync_feed_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTHS,
    parameter int DEPTH      = FEED_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      ovf,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      v,
    input  logic                      f
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [1:0]            state;
    logic [1:0]            state_nx;
    logic [DATA_WIDTH-1:0] head;
    logic                  wr_acc;
    logic                  pop;

    // full is judged before any pop in the same cycle
    assign full   = (level == FULL_LVL);
    assign empty  = (level == '0);
    assign wr_acc = wr & ~full;
    assign pop    = (state == ST_IDLE) & ~empty & ~f;
    assign v      = (state == ST_ISSUE);

    sync_feed_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (wr_data),
        .raddr (rptr),
        .rdata (head)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:      if (pop) state_nx = ST_ISSUE;
            ST_ISSUE:     state_nx = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (f) state_nx = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!f) state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            ovf      <= 1'b0;
            out_data <= '0;
        end else begin
            state <= state_nx;
            if (wr_acc) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr     <= rptr + AW'(1);
                out_data <= head;
            end
            if (wr && full) begin
                ovf <= 1'b1;
            end
            unique case ({wr_acc, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule
